// File: rtl/riscv_dmem_responder_pkg.sv
// riscv_dmem_responder_pkg
//   Shared definitions for the data-memory responder: data width, RV32I
//   load/store funct3 codes and the responder FSM state encoding.
//   No ports; imported by riscv_dmem_lane_align and riscv_dmem_responder.
package riscv_dmem_responder_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    DMRSP_IDLE = 2'd0,
    DMRSP_WAIT = 2'd1,
    DMRSP_RESP = 2'd2
  } dmrsp_state_t;

endpackage

// File: rtl/riscv_dmem_lane_align.sv
// riscv_dmem_lane_align
//   Combinational byte-lane steering for RV32I loads and stores.
//   Ports:
//     funct3    in  3     size/sign code
//     addr_lo   in  2     byte offset within the word
//     wdata     in  XLEN  right-justified store data
//     rdword    in  XLEN  raw word read from the array
//     byte_we   out 4     per-lane write enable (zero when misaligned)
//     wword     out XLEN  store data replicated onto the lanes
//     rdata_ext out XLEN  selected and sign/zero-extended load data
//     misalign  out 1     misaligned access or illegal funct3
module riscv_dmem_lane_align
  import riscv_dmem_responder_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdword,
  output logic [3:0]      byte_we,
  output logic [XLEN-1:0] wword,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misalign
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    byte_we   = 4'b0000;
    wword     = wdata;
    rdata_ext = rdword;
    misalign  = 1'b0;
    sel_b     = rdword[{addr_lo, 3'b000} +: 8];
    sel_h     = addr_lo[1] ? rdword[31:16] : rdword[15:0];
    case (funct3)
      FUNCT3_LB, FUNCT3_LBU: begin
        byte_we   = 4'b0001 << addr_lo;
        wword     = {4{wdata[7:0]}};
        // funct3[2] set means the unsigned variant
        rdata_ext = {{24{sel_b[7] & ~funct3[2]}}, sel_b};
      end
      FUNCT3_LH, FUNCT3_LHU: begin
        misalign  = addr_lo[0];
        byte_we   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword     = {2{wdata[15:0]}};
        rdata_ext = {{16{sel_h[15] & ~funct3[2]}}, sel_h};
      end
      FUNCT3_LW: begin
        misalign = |addr_lo;
        byte_we  = 4'b1111;
      end
      // 011, 110, 111 are not legal load/store sizes
      default: misalign = 1'b1;
    endcase
    if (misalign) byte_we = 4'b0000;
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder
//   Slave end of the memory-stage load/store port. One request at a time,
//   LATENCY wait states, then a registered response.
//   Ports:
//     i_clk, i_rst           clock, synchronous active-high reset
//     i_req_valid/o_req_ready request handshake
//     i_req_we, i_req_funct3, i_req_addr, i_req_wdata  request payload
//     o_rsp_valid/i_rsp_ready response handshake
//     o_rsp_rdata, o_rsp_err  response payload
//     o_busy                  request accepted, response not yet consumed
//     o_dbg_state             current FSM state
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. o_req_ready is high only in IDLE; o_rsp_valid is high only in
//   RESP and its payload stays stable until i_rsp_ready is seen.
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_busy,
  output dmrsp_state_t    o_dbg_state
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  dmrsp_state_t    state, state_nxt;
  logic [3:0]      cnt;
  logic            q_we;
  logic [2:0]      q_funct3;
  logic [XLEN-1:0] q_addr;
  logic [XLEN-1:0] q_wdata;

  logic [XLEN-1:0] mem [DEPTH];

  logic            accept;
  logic            commit;
  logic            a_we;
  logic [2:0]      a_funct3;
  logic [XLEN-1:0] a_addr;
  logic [XLEN-1:0] a_wdata;
  logic [AW-1:0]   idx;
  logic [3:0]      byte_we;
  logic [XLEN-1:0] wword;
  logic [XLEN-1:0] rdata_ext;
  logic            misalign;

  assign o_req_ready = (state == DMRSP_IDLE);
  assign o_busy      = (state != DMRSP_IDLE);
  assign o_dbg_state = state;
  assign accept      = i_req_valid && (state == DMRSP_IDLE);

  // With LATENCY==0 the commit edge is the accept edge, so the request has
  // to come straight from the ports rather than from the latches.
  assign a_we     = (state == DMRSP_IDLE) ? i_req_we     : q_we;
  assign a_funct3 = (state == DMRSP_IDLE) ? i_req_funct3 : q_funct3;
  assign a_addr   = (state == DMRSP_IDLE) ? i_req_addr   : q_addr;
  assign a_wdata  = (state == DMRSP_IDLE) ? i_req_wdata  : q_wdata;
  assign idx      = a_addr[AW+1:2];

  riscv_dmem_lane_align u_align (
    .funct3   (a_funct3),
    .addr_lo  (a_addr[1:0]),
    .wdata    (a_wdata),
    .rdword   (mem[idx]),
    .byte_we  (byte_we),
    .wword    (wword),
    .rdata_ext(rdata_ext),
    .misalign (misalign)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      DMRSP_IDLE: if (accept) state_nxt = (LATENCY == 0) ? DMRSP_RESP : DMRSP_WAIT;
      DMRSP_WAIT: if (cnt <= 4'd1) state_nxt = DMRSP_RESP;
      DMRSP_RESP: if (i_rsp_ready) state_nxt = DMRSP_IDLE;
      default:    state_nxt = DMRSP_IDLE;
    endcase
  end

  // Array access and response capture both happen on the edge entering RESP.
  assign commit = (state_nxt == DMRSP_RESP) && (state != DMRSP_RESP);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= DMRSP_IDLE;
      cnt         <= 4'd0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_rsp_valid <= (state_nxt == DMRSP_RESP);
      if (accept) begin
        q_we     <= i_req_we;
        q_funct3 <= i_req_funct3;
        q_addr   <= i_req_addr;
        q_wdata  <= i_req_wdata;
        cnt      <= LAT4;
      end else if (state == DMRSP_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        o_rsp_err   <= misalign;
        o_rsp_rdata <= (a_we || misalign) ? '0 : rdata_ext;
      end
    end
  end

  // Array contents survive reset; a store is only dropped if reset lands
  // before its commit edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst && commit && a_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_we[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb_riscv_dmem_responder
//   Directed bench for riscv_dmem_responder. Three instances differ only in
//   LATENCY (1, 0, 3); request payload wires are shared, valid/ready per
//   instance.
module tb_riscv_dmem_responder;
  import riscv_dmem_responder_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  req_valid = 3'b000;
  logic [2:0]  rsp_ready = 3'b000;
  logic        req_we    = 1'b0;
  logic [2:0]  req_f3    = 3'b000;
  logic [31:0] req_addr  = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic         req_ready_0, req_ready_1, req_ready_2;
  logic         rsp_valid_0, rsp_valid_1, rsp_valid_2;
  logic         rsp_err_0, rsp_err_1, rsp_err_2;
  logic         busy_0, busy_1, busy_2;
  logic [31:0]  rdata_0, rdata_1, rdata_2;
  dmrsp_state_t st_0, st_1, st_2;

  int total = 0;
  int bad   = 0;

  riscv_dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[0]), .o_req_ready(req_ready_0),
    .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid_0), .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rdata_0),
    .o_rsp_err(rsp_err_0), .o_busy(busy_0), .o_dbg_state(st_0)
  );

  riscv_dmem_responder #(.DEPTH(1024), .LATENCY(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[1]), .o_req_ready(req_ready_1),
    .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid_1), .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rdata_1),
    .o_rsp_err(rsp_err_1), .o_busy(busy_1), .o_dbg_state(st_1)
  );

  riscv_dmem_responder #(.DEPTH(1024), .LATENCY(3)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[2]), .o_req_ready(req_ready_2),
    .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid_2), .i_rsp_ready(rsp_ready[2]), .o_rsp_rdata(rdata_2),
    .o_rsp_err(rsp_err_2), .o_busy(busy_2), .o_dbg_state(st_2)
  );

  // instance-indexed views of the outputs
  function automatic logic g_req_ready(input int k);
    return (k == 0) ? req_ready_0 : (k == 1) ? req_ready_1 : req_ready_2;
  endfunction
  function automatic logic g_rsp_valid(input int k);
    return (k == 0) ? rsp_valid_0 : (k == 1) ? rsp_valid_1 : rsp_valid_2;
  endfunction
  function automatic logic g_rsp_err(input int k);
    return (k == 0) ? rsp_err_0 : (k == 1) ? rsp_err_1 : rsp_err_2;
  endfunction
  function automatic logic g_busy(input int k);
    return (k == 0) ? busy_0 : (k == 1) ? busy_1 : busy_2;
  endfunction
  function automatic logic [31:0] g_rdata(input int k);
    return (k == 0) ? rdata_0 : (k == 1) ? rdata_1 : rdata_2;
  endfunction
  function automatic logic [1:0] g_state(input int k);
    return (k == 0) ? st_0 : (k == 1) ? st_1 : st_2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: present one request for one edge (instance must be idle)
  task automatic issue(input int k, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_we    = we;
    req_f3    = f3;
    req_addr  = a;
    req_wdata = wd;
    req_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
  endtask

  // count edges after the accept edge until rsp_valid; bounded
  task automatic wait_rsp(input int k, input int exp_lat, input string tag);
    int n;
    n = 0;
    while (g_rsp_valid(k) !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic consume(input int k, input string tag);
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    chk({tag, ".idle_ready"}, 32'(g_req_ready(k)), 32'd1);
    chk({tag, ".idle_valid"}, 32'(g_rsp_valid(k)), 32'd0);
  endtask

  task automatic txn(input int k, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int lat,
                     input logic [31:0] exp_rd, input logic exp_err, input string tag);
    issue(k, we, f3, a, wd);
    wait_rsp(k, lat, tag);
    chk({tag, ".rdata"}, g_rdata(k), exp_rd);
    chk({tag, ".err"}, 32'(g_rsp_err(k)), 32'(exp_err));
    consume(k, tag);
  endtask

  initial begin
    logic [31:0] held_rd;
    logic        held_err;

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 32'(req_ready_0), 32'd1);
    chk("rst.valid", 32'(rsp_valid_0), 32'd0);
    chk("rst.rdata", rdata_0, 32'h0);
    chk("rst.err", 32'(rsp_err_0), 32'd0);
    chk("rst.busy", 32'(busy_0), 32'd0);
    chk("rst.state", 32'(st_0), 32'(DMRSP_IDLE));
    rst = 1'b0;

    // reset mid-WAIT drops the in-flight store (LATENCY=3)
    txn(2, 1'b1, FUNCT3_SW, 32'h20, 32'hAAAA5555, 3, 32'h0, 1'b0, "t1.sw_pre");
    issue(2, 1'b1, FUNCT3_SW, 32'h20, 32'h12345678);
    @(posedge clk);
    #1;
    chk("t1.in_wait", 32'(g_state(2)), 32'(DMRSP_WAIT));
    chk("t1.busy", 32'(g_busy(2)), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t1.state", 32'(g_state(2)), 32'(DMRSP_IDLE));
    chk("t1.ready", 32'(g_req_ready(2)), 32'd1);
    chk("t1.valid", 32'(g_rsp_valid(2)), 32'd0);
    txn(2, 1'b0, FUNCT3_LW, 32'h20, 32'h0, 3, 32'hAAAA5555, 1'b0, "t1.lw");

    // store then load (LATENCY=1)
    txn(0, 1'b1, FUNCT3_SW, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0, "t2.sw");
    txn(0, 1'b0, FUNCT3_LW, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0, "t2.lw");

    // byte store and sign/zero extension
    txn(0, 1'b1, FUNCT3_SB, 32'h11, 32'h00000080, 1, 32'h0, 1'b0, "t3.sb");
    txn(0, 1'b0, FUNCT3_LB, 32'h11, 32'h0, 1, 32'hFFFFFF80, 1'b0, "t3.lb");
    txn(0, 1'b0, FUNCT3_LBU, 32'h11, 32'h0, 1, 32'h00000080, 1'b0, "t3.lbu");
    txn(0, 1'b0, FUNCT3_LW, 32'h10, 32'h0, 1, 32'hDEAD80EF, 1'b0, "t3.lw");
    txn(0, 1'b0, FUNCT3_LH, 32'h12, 32'h0, 1, 32'hFFFFDEAD, 1'b0, "t3.lh");
    txn(0, 1'b0, FUNCT3_LHU, 32'h12, 32'h0, 1, 32'h0000DEAD, 1'b0, "t3.lhu");

    // errors: no write, rdata 0, normal latency
    txn(0, 1'b1, FUNCT3_SH, 32'h13, 32'h00001234, 1, 32'h0, 1'b1, "t4.sh_mis");
    txn(0, 1'b0, FUNCT3_LW, 32'h10, 32'h0, 1, 32'hDEAD80EF, 1'b0, "t4.lw_chk");
    txn(0, 1'b0, FUNCT3_LW, 32'h12, 32'h0, 1, 32'h0, 1'b1, "t4.lw_mis");
    txn(0, 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1, "t4.f3_011");
    txn(0, 1'b1, 3'b111, 32'h10, 32'hFFFFFFFF, 1, 32'h0, 1'b1, "t4.st_f3_111");
    txn(0, 1'b1, FUNCT3_SH, 32'h12, 32'hBEEF5678, 1, 32'h0, 1'b0, "t4.sh_hi");
    txn(0, 1'b0, FUNCT3_LW, 32'h10, 32'h0, 1, 32'h567880EF, 1'b0, "t4.lw_after");

    // response backpressure: payload stable, no new accept
    issue(0, 1'b0, FUNCT3_LW, 32'h10, 32'h0);
    wait_rsp(0, 1, "t5");
    held_rd  = rdata_0;
    held_err = rsp_err_0;
    chk("t5.rdata", held_rd, 32'h567880EF);
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t5.hold_valid", 32'(rsp_valid_0), 32'd1);
      chk("t5.hold_rdata", rdata_0, 32'h567880EF);
      chk("t5.hold_err", 32'(rsp_err_0), 32'(held_err));
      chk("t5.hold_ready", 32'(req_ready_0), 32'd0);
    end
    req_valid[0] = 1'b0;
    consume(0, "t5");

    // zero latency and address aliasing modulo 4*DEPTH
    txn(1, 1'b1, FUNCT3_SW, 32'h1000, 32'hCAFEF00D, 0, 32'h0, 1'b0, "t6.sw");
    txn(1, 1'b0, FUNCT3_LW, 32'h0, 32'h0, 0, 32'hCAFEF00D, 1'b0, "t6.lw_alias");
    txn(1, 1'b0, FUNCT3_LH, 32'h2002, 32'h0, 0, 32'hFFFFCAFE, 1'b0, "t6.lh_alias");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
